// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter for the byte-write channel of one UART transmitter.
//
// Up to NREQ byte producers compete for the channel. When the arbiter is idle it picks one
// requester and grants it for a burst of up to BURST accepted bytes. It then returns to
// arbitration, and priority rotates to the next index. The downstream valid/ready/data
// handshake is passed through combinationally from the granted requester. Nothing is buffered.
//
// Optional feature (macro UART_ARB_TAG_EN): an HDR state is placed between ARB and GRANT.
// In HDR the arbiter sends one tag byte, TAG_BASE + grant index, ahead of each burst.
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   i_req_valid  per-requester byte valid
//   o_req_ready  per-requester byte accepted (only the granted index can be high)
//   i_req_data   packed bytes; requester k at [k*DLEN +: DLEN]
//   o_wvalid     to transmitter i_wvalid
//   i_wready     from transmitter o_wready
//   o_wdata      to transmitter i_wdata
//   o_grant      registered one-hot grant, zero while arbitrating
//   o_busy       high in any state other than ARB
module uart_tx_arb #(
    parameter int              NREQ     = 4,
    parameter int              DLEN     = 8,
    parameter int              BURST    = 4,
    parameter logic [DLEN-1:0] TAG_BASE = 8'hA0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*DLEN-1:0] i_req_data,
    output logic                 o_wvalid,
    input  logic                 i_wready,
    output logic [DLEN-1:0]      o_wdata,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_busy
);

    localparam int            IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int            BW    = $clog2(BURST) + 1;
    localparam logic [IW-1:0] LAST  = IW'(NREQ - 1);
    localparam logic [BW-1:0] BLAST = BW'(BURST - 1);

`ifdef UART_ARB_TAG_EN
    typedef enum logic [1:0] {ARB = 2'd0, GRANT = 2'd1, HDR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ARB = 2'd0, GRANT = 2'd1} state_t;
    logic [DLEN-1:0] unused_tag;
    assign unused_tag = TAG_BASE;
`endif

    state_t          state, state_n;
    logic [NREQ-1:0] gnt, gnt_n;
    logic [IW-1:0]   gidx, gidx_n;   // binary index of the current grant
    logic [IW-1:0]   ptr, ptr_n;     // first index scanned in ARB
    logic [BW-1:0]   bct, bct_n;     // bytes accepted in the current burst
    logic [IW-1:0]   scan, pick, ptr_rot;
    logic            hit;

    // Priority moves to the index just after the requester being released.
    assign ptr_rot = (gidx == LAST) ? '0 : gidx + IW'(1);
    assign o_grant = gnt;

    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        gidx_n      = gidx;
        ptr_n       = ptr;
        bct_n       = bct;
        o_wvalid    = 1'b0;
        o_wdata     = '0;
        o_req_ready = '0;
        o_busy      = 1'b0;
        hit         = 1'b0;
        pick        = '0;
        scan        = '0;

        // Rotating scan: the first valid requester at or after ptr wins.
        for (int i = 0; i < NREQ; i++) begin
            scan = IW'((int'(ptr) + i) % NREQ);
            if (!hit && i_req_valid[scan]) begin
                hit  = 1'b1;
                pick = scan;
            end
        end

        case (state)
            ARB: begin
                if (hit) begin
                    gnt_n       = '0;
                    gnt_n[pick] = 1'b1;
                    gidx_n      = pick;
                    bct_n       = '0;
`ifdef UART_ARB_TAG_EN
                    state_n     = HDR;
`else
                    state_n     = GRANT;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            // The tag is always sent once it starts, so a valid byte is never withdrawn.
            HDR: begin
                o_busy   = 1'b1;
                o_wvalid = 1'b1;
                o_wdata  = TAG_BASE + DLEN'(gidx);
                if (i_wready) begin
                    state_n = GRANT;
                    bct_n   = '0;
                end
            end
`endif
            GRANT: begin
                o_busy             = 1'b1;
                o_wvalid           = i_req_valid[gidx];
                o_wdata            = i_req_data[int'(gidx)*DLEN +: DLEN];
                o_req_ready[gidx]  = i_wready;
                // Release only when no byte is pending, or when the last byte of the burst is taken.
                if (!i_req_valid[gidx] || (i_wready && bct == BLAST)) begin
                    state_n = ARB;
                    ptr_n   = ptr_rot;
                    bct_n   = '0;
                    gnt_n   = '0;
                end else if (i_wready) begin
                    bct_n = bct + BW'(1);
                end
            end
            default: begin
                state_n = ARB;
                gnt_n   = '0;
                gidx_n  = '0;
                ptr_n   = '0;
                bct_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ARB;
            gnt   <= '0;
            gidx  <= '0;
            ptr   <= '0;
            bct   <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            gidx  <= gidx_n;
            ptr   <= ptr_n;
            bct   <= bct_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: self-checking bench for uart_tx_arb with NREQ=4, DLEN=8, BURST=4.
// Inputs change 1 time unit after the rising edge, and outputs are sampled on the falling edge.
// The bench has three parts:
//   - a table of per-cycle vectors starting from reset;
//   - hand-written multi-cycle sequences;
//   - a randomized run checked against a grant/burst reference model.
module tb_uart_tx_arb;
    localparam int         NREQ     = 4;
    localparam int         DLEN     = 8;
    localparam int         BURST    = 4;
    localparam logic [7:0] TAG_BASE = 8'hA0;
`ifdef UART_ARB_TAG_EN
    localparam bit TAG_ON = 1'b1;
`else
    localparam bit TAG_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid, req_ready, grant;
    logic [NREQ*DLEN-1:0] req_data;
    logic                 wvalid, wready, busy;
    logic [DLEN-1:0]      wdata;

    int tests = 0;
    int fails = 0;

    uart_tx_arb #(.NREQ(NREQ), .DLEN(DLEN), .BURST(BURST), .TAG_BASE(TAG_BASE)) dut (
        .clk(clk), .rstn(rstn),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_data(req_data),
        .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata),
        .o_grant(grant), .o_busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        wready    = 1'b0;
        post();
        post();
        rstn = 1'b1;
    endtask

    // Wait for a non-zero grant. If strict is set, the first non-zero grant must equal g.
    // Otherwise the bench keeps waiting until grant equals g.
    task automatic wait_grant(input logic [3:0] g, input bit strict, input string nm);
        int c;
        for (c = 0; c < 40; c++) begin
            smp();
            if (grant != 0 && (strict || grant == g)) break;
            post();
        end
        check(nm, (c < 40) ? {28'h0, grant} : 32'hDEAD, {28'h0, g});
    endtask

    typedef struct packed {
        logic [3:0] v;
        logic       rdy;
        logic [3:0] g;
        logic       wv;
        logic [3:0] r;
        logic       b;
        logic [7:0] d;
    } vec_t;

    vec_t       tbl[15];
    logic [7:0] s1_bytes[5];
    logic [7:0] seen[$];
    int         idx, n, bubble, gaps;
    bit         done;

    // reference model state
    int         owner, sent, rptr, acc;
    bit         hdr, found;
    int         wait_cnt[NREQ];
    logic [1:0] ow;
    logic [3:0] e_g, e_r;
    logic       e_wv, e_b;
    logic [7:0] e_d;

    initial begin
        rstn = 1'b0; req_valid = '0; req_data = '0; wready = 1'b0;
        #3;
        check("reset_state", {grant, wvalid, req_ready, busy, wdata}, 32'h0);
        do_reset();

`ifndef UART_ARB_TAG_EN
        // Requesters 0 and 2 are valid with fixed bytes C0/C2, starting from ptr=0.
        tbl[0]  = '{4'b0101, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[1]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hC0};
        tbl[2]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hC0};
        tbl[3]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hC0};
        tbl[4]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hC0};
        tbl[5]  = '{4'b0101, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[6]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC2};
        tbl[7]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC2};
        tbl[8]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC2};
        tbl[9]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC2};
        tbl[10] = '{4'b0101, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[11] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hC0};
        tbl[12] = '{4'b0100, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'hC0};
        tbl[13] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[14] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1, 8'hC2};
        req_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].v;
            wready    = tbl[i].rdy;
            smp();
            check($sformatf("tbl%0d", i), {grant, wvalid, req_ready, busy, wdata},
                  {tbl[i].g, tbl[i].wv, tbl[i].r, tbl[i].b, tbl[i].d});
            post();
        end
`endif

        // Single requester 2 streams five bytes while wready pulses once every 10 cycles.
        s1_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        do_reset();
        idx = 0; bubble = 0; gaps = 0;
        for (int c = 0; c < 300 && idx < 5; c++) begin
            req_valid = 4'b0100;
            req_data  = {8'h00, s1_bytes[idx], 16'h0000};
            wready    = (c % 10 == 9);
            smp();
            if (grant == 0 && idx >= 1 && idx <= 3) gaps++;
            if (grant == 0 && idx == 4) bubble++;
            if (req_ready[2] && wready) begin
                check($sformatf("s1_byte%0d", idx), wdata, s1_bytes[idx]);
                check($sformatf("s1_grant%0d", idx), grant, 4'b0100);
                if (idx == 4) check("s1_bubble", bubble > 0, 1);
                idx++;
            end
            post();
        end
        check("s1_count", idx, 5);
        check("s1_no_early_release", gaps, 0);

        // Backpressure: requester 1 is granted, but wready stays low for 50 cycles.
        do_reset();
        req_valid = 4'b0010;
        req_data  = {16'h0, 8'h77, 8'h00};
        wait_grant(4'b0010, 1'b1, "bp_grant");
        for (int i = 0; i < 50; i++) begin
            check($sformatf("bp_hold%0d", i), {grant, wvalid, req_ready, busy, wdata},
                  {4'b0010, 1'b1, 4'b0000, 1'b1, TAG_ON ? 8'hA1 : 8'h77});
            post();
            smp();
        end

        // Early release: requester 3 sends two bytes and then drops valid.
        do_reset();
        req_valid = 4'b1000;
        wready    = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 2; c++) begin
            req_data = {(n == 0) ? 8'h31 : 8'h32, 24'h0};
            smp();
            if (req_ready[3] && wready) begin
                check($sformatf("er_byte%0d", n), wdata, (n == 0) ? 8'h31 : 8'h32);
                n++;
            end
            post();
        end
        check("er_count", n, 2);
        req_valid = 4'b0011;
        smp();
        check("er_release_cycle", {grant, wvalid}, {4'b1000, 1'b0});
        post();
        smp();
        check("er_bubble", grant, 4'b0000);
        post();
        wait_grant(4'b0001, 1'b1, "er_next_is_req0");

        // Reset mid-GRANT: reach req3 so that ptr is non-zero, then reset asynchronously.
        do_reset();
        req_valid = 4'b1010;
        req_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        wready    = 1'b1;
        wait_grant(4'b1000, 1'b0, "rst_reach_req3");
        #2 rstn = 1'b0;
        #1 check("rst_async", {grant, wvalid, req_ready, busy}, 32'h0);
        req_valid = 4'b1111;
        post();
        post();
        rstn = 1'b1;
        wait_grant(4'b0001, 1'b1, "rst_req0_first");

        // Tag header: requester 1 sends 5A. The transmitter sees A1 first only when tagging is on.
        do_reset();
        req_valid = 4'b0010;
        req_data  = {16'h0, 8'h5A, 8'h00};
        wready    = 1'b1;
        seen.delete();
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            smp();
            if (wvalid && wready) seen.push_back(wdata);
            if (req_ready[1]) done = 1'b1;
            post();
        end
        req_valid = '0;
        check("tag_count", seen.size(), TAG_ON ? 2 : 1);
        check("tag_first", (seen.size() > 0) ? seen[0] : 8'h00, TAG_ON ? 8'hA1 : 8'h5A);
        check("tag_last", (seen.size() > 0) ? seen[seen.size()-1] : 8'h00, 8'h5A);

        // Randomized run against the reference model.
        do_reset();
        owner = -1; sent = 0; rptr = 0; hdr = 1'b0;
        for (int k = 0; k < NREQ; k++) wait_cnt[k] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            smp();
            e_g = '0; e_r = '0; e_wv = 1'b0; e_b = 1'b0; e_d = '0;
            ow  = owner[1:0];
            if (owner >= 0) begin
                e_g[ow] = 1'b1;
                e_b     = 1'b1;
                if (hdr) begin
                    e_wv = 1'b1;
                    e_d  = TAG_BASE + 8'(owner);
                end else begin
                    e_wv    = req_valid[ow];
                    e_d     = req_data[owner*8 +: 8];
                    e_r[ow] = wready;
                end
            end
            check($sformatf("rnd%0d", cyc), {grant, wvalid, req_ready, busy, wdata},
                  {e_g, e_wv, e_r, e_b, e_d});
            acc = -1;
            if (owner >= 0 && !hdr && req_valid[ow] && wready) acc = owner;
            if (acc >= 0) begin
                for (int k = 0; k < NREQ; k++)
                    if (k != acc && req_valid[k]) wait_cnt[k]++;
                check($sformatf("fair%0d", cyc), wait_cnt[acc] <= (NREQ-1)*BURST, 1);
                wait_cnt[acc] = 0;
            end
            // Advance the model: arbitration, header, burst count and release.
            if (owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req_valid[(rptr + k) % NREQ]) begin
                        found = 1'b1;
                        owner = (rptr + k) % NREQ;
                        sent  = 0;
                        hdr   = TAG_ON;
                    end
                end
            end else if (hdr) begin
                if (wready) hdr = 1'b0;
            end else if (!req_valid[ow]) begin
                rptr  = (owner + 1) % NREQ;
                owner = -1;
            end else if (wready) begin
                sent++;
                if (sent == BURST) begin
                    rptr  = (owner + 1) % NREQ;
                    owner = -1;
                    sent  = 0;
                end
            end
            post();
            for (int k = 0; k < NREQ; k++) begin
                if (acc == k) begin
                    req_valid[k]       = 1'($urandom_range(0, 1));
                    req_data[k*8 +: 8] = 8'($urandom);
                end else if (!req_valid[k]) begin
                    req_valid[k]       = ($urandom_range(0, 2) == 0);
                    req_data[k*8 +: 8] = 8'($urandom);
                    wait_cnt[k]        = 0;
                end
            end
            wready = 1'($urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
